// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and pointer helpers for the dual-clock FIFO halves
//
// Purpose: FSM state encoding, DEPTH derivation and Gray/binary pointer
// conversion shared by the write-side and read-side halves of the FIFO.
// Ports: none (package).
// Helpers operate on a fixed PTR_MAX_W-bit word; callers zero-extend their
// pointer and take back the low bits.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef enum logic {
    ST_BUSY = 1'b0,
    ST_RUN  = 1'b1
  } fifo_state_e;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/cdc_sync_2ff.sv
// rtl/cdc_sync_2ff.sv - two-flop synchronizer for a multi-bit Gray-coded bus
//
// Purpose: brings a Gray-coded pointer from a foreign clock domain into clk.
// Only one bit changes per step, so per-bit synchronization is coherent.
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous, active-low reset (clears both stages)
//   d    in   W-bit value from the source domain
//   q    out  W-bit value, two clk edges later
module cdc_sync_2ff
  import fifo_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/async_fifo_wr_port.sv
// rtl/async_fifo_wr_port.sv - write-side half of the dual-clock FIFO
//
// Purpose: owns the write pointer, the RAM write port, full/almost_full and
// occupancy generation, and the post-reset busy window. Exports the Gray
// write pointer and takes the read pointer back through a 2-FF synchronizer.
// Optional macro ASYNC_FIFO_WR_STATUS_EN: when defined, wr_ack/overflow are
// generated; otherwise both are tied low and their flops are absent.
// Ports:
//   wr_clk         in   write clock
//   rst            in   asynchronous, active-low reset
//   wr_en          in   write request
//   wr_data        in   write data (DW)
//   rd_ptr_gray    in   read pointer, Gray, read clock domain (AW+1)
//   wr_ptr_gray    out  registered write pointer, Gray (AW+1)
//   mem_we         out  RAM write enable
//   mem_waddr      out  RAM write address (AW)
//   mem_wdata      out  RAM write data (DW)
//   full           out  FIFO full
//   almost_full    out  occupancy >= DEPTH-AF_GAP
//   wr_rst_busy    out  post-reset busy window
//   wr_data_count  out  occupancy seen from the write side, 0..DEPTH (AW+1)
//   wr_ack         out  previous-cycle write accepted
//   overflow       out  previous-cycle write rejected because full
module async_fifo_wr_port
  import fifo_pkg::*;
#(
  parameter int DW           = 8,
  parameter int AW           = 8,
  parameter int AF_GAP       = 1,
  parameter int RST_BUSY_CYC = 4
) (
  input  logic          wr_clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic [AW:0]   rd_ptr_gray,
  output logic [AW:0]   wr_ptr_gray,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          full,
  output logic          almost_full,
  output logic          wr_rst_busy,
  output logic [AW:0]   wr_data_count,
  output logic          wr_ack,
  output logic          overflow
);

  localparam int            DEPTH     = fifo_depth(AW);
  localparam logic [AW:0]   AF_LEVEL  = (AW+1)'(DEPTH - AF_GAP);
  localparam int            BCW       = (RST_BUSY_CYC > 1) ? $clog2(RST_BUSY_CYC) : 1;
  localparam logic [BCW-1:0] BUSY_LAST = BCW'(RST_BUSY_CYC - 1);

  fifo_state_e    state_q, state_d;
  logic [BCW-1:0] busy_cnt_q, busy_cnt_d;
  logic [AW:0]    wr_ptr_bin_q, wr_ptr_bin_d;
  logic [AW:0]    wr_ptr_gray_q, wr_ptr_gray_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_waddr_q, mem_waddr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           full_q, full_d;
  logic           almost_full_q, almost_full_d;
  logic [AW:0]    count_q, count_d;

  logic [AW:0]          rd_sync;
  logic [AW:0]          rd_bin;
  logic [PTR_MAX_W-1:0] rd_bin_w;
  logic [AW:0]          nxt_bin;
  logic [AW:0]          nxt_gray;
  logic [PTR_MAX_W-1:0] nxt_gray_w;
  logic                 run;
  logic                 wr_accept;
  logic                 full_calc;
  logic                 af_calc;
  logic [AW:0]          count_calc;
  logic                 unused_hi;

  cdc_sync_2ff #(.W(AW+1)) u_rd_sync (
    .clk (wr_clk),
    .rst (rst),
    .d   (rd_ptr_gray),
    .q   (rd_sync)
  );

  assign run       = (state_q == ST_RUN);
  // Registered full gates acceptance, so a write on the edge where full
  // rises still lands and the following request is the one rejected.
  assign wr_accept = run & wr_en & ~full_q;

  assign nxt_bin    = wr_ptr_bin_q + {{AW{1'b0}}, wr_accept};
  assign nxt_gray_w = bin2gray(PTR_MAX_W'(nxt_bin));
  assign nxt_gray   = nxt_gray_w[AW:0];

  assign rd_bin_w = gray2bin(PTR_MAX_W'(rd_sync));
  assign rd_bin   = rd_bin_w[AW:0];

  // Upper helper bits are always zero for zero-extended pointers.
  assign unused_hi = ^{rd_bin_w[PTR_MAX_W-1:AW+1], nxt_gray_w[PTR_MAX_W-1:AW+1]};

  // Full when the write pointer is exactly one lap ahead: in Gray form
  // that is the top two bits inverted and the rest equal.
  assign full_calc  = (nxt_gray == {~rd_sync[AW:AW-1], rd_sync[AW-2:0]});
  assign count_calc = nxt_bin - rd_bin;
  assign af_calc    = (count_calc >= AF_LEVEL);

  always_comb begin
    state_d       = state_q;
    busy_cnt_d    = busy_cnt_q;
    wr_ptr_bin_d  = nxt_bin;
    wr_ptr_gray_d = nxt_gray;
    mem_we_d      = wr_accept;
    mem_waddr_d   = wr_accept ? wr_ptr_bin_q[AW-1:0] : mem_waddr_q;
    mem_wdata_d   = wr_accept ? wr_data : mem_wdata_q;
    full_d        = 1'b1;
    almost_full_d = 1'b1;
    count_d       = '0;

    case (state_q)
      ST_BUSY: begin
        if (busy_cnt_q == BUSY_LAST) begin
          state_d = ST_RUN;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
    endcase

    // Flags hold their pessimistic reset values while busy and pick up the
    // computed values on the very edge that leaves BUSY.
    if (state_d == ST_RUN) begin
      full_d        = full_calc;
      almost_full_d = af_calc;
      count_d       = count_calc;
    end
  end

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BUSY;
      busy_cnt_q    <= '0;
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      mem_we_q      <= 1'b0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      full_q        <= 1'b1;
      almost_full_q <= 1'b1;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      busy_cnt_q    <= busy_cnt_d;
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      mem_we_q      <= mem_we_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      count_q       <= count_d;
    end
  end

  assign wr_ptr_gray   = wr_ptr_gray_q;
  assign mem_we        = mem_we_q;
  assign mem_waddr     = mem_waddr_q;
  assign mem_wdata     = mem_wdata_q;
  assign full          = full_q;
  assign almost_full   = almost_full_q;
  assign wr_rst_busy   = ~run;
  assign wr_data_count = count_q;

`ifdef ASYNC_FIFO_WR_STATUS_EN
  logic wr_reject;
  logic wr_ack_q, wr_ack_d;
  logic overflow_q, overflow_d;

  assign wr_reject = run & wr_en & full_q;

  always_comb begin
    wr_ack_d   = wr_accept;
    overflow_d = wr_reject;
  end

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      wr_ack_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ack_q   <= wr_ack_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_ack   = wr_ack_q;
  assign overflow = overflow_q;
`else
  assign wr_ack   = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_port.sv
// tb/tb_async_fifo_wr_port.sv - self-checking bench for async_fifo_wr_port
//
// Purpose: random write/read-pointer stimulus checked every cycle against an
// occupancy-counting reference model; a second instance with AF_GAP=16
// exercises the wider almost_full threshold on the same stimulus.
module tb_async_fifo_wr_port;

  localparam int DW           = 8;
  localparam int AW           = 8;
  localparam int DEPTH        = 256;
  localparam int AF_GAP       = 1;
  localparam int AF_GAP_B     = 16;
  localparam int RST_BUSY_CYC = 4;

  logic          wr_clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   rd_ptr_gray = '0;

  logic [AW:0]   wr_ptr_gray;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          full;
  logic          almost_full;
  logic          wr_rst_busy;
  logic [AW:0]   wr_data_count;
  logic          wr_ack;
  logic          overflow;

  logic [AW:0]   b_wr_ptr_gray;
  logic          b_mem_we;
  logic [AW-1:0] b_mem_waddr;
  logic [DW-1:0] b_mem_wdata;
  logic          b_full;
  logic          b_almost_full;
  logic          b_wr_rst_busy;
  logic [AW:0]   b_wr_data_count;
  logic          b_wr_ack;
  logic          b_overflow;

  async_fifo_wr_port #(.DW(DW), .AW(AW), .AF_GAP(AF_GAP), .RST_BUSY_CYC(RST_BUSY_CYC)) dut (
    .wr_clk        (wr_clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_ptr_gray   (rd_ptr_gray),
    .wr_ptr_gray   (wr_ptr_gray),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .full          (full),
    .almost_full   (almost_full),
    .wr_rst_busy   (wr_rst_busy),
    .wr_data_count (wr_data_count),
    .wr_ack        (wr_ack),
    .overflow      (overflow)
  );

  async_fifo_wr_port #(.DW(DW), .AW(AW), .AF_GAP(AF_GAP_B), .RST_BUSY_CYC(RST_BUSY_CYC)) dut_b (
    .wr_clk        (wr_clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_ptr_gray   (rd_ptr_gray),
    .wr_ptr_gray   (b_wr_ptr_gray),
    .mem_we        (b_mem_we),
    .mem_waddr     (b_mem_waddr),
    .mem_wdata     (b_mem_wdata),
    .full          (b_full),
    .almost_full   (b_almost_full),
    .wr_rst_busy   (b_wr_rst_busy),
    .wr_data_count (b_wr_data_count),
    .wr_ack        (b_wr_ack),
    .overflow      (b_overflow)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: total words written/read as plain integers; the write
  // side sees the read total that was presented two edges earlier.
  int wr_total, rd_total, rd_s1, rd_s2;
  int busy_left;
  bit m_run, m_full, m_af, m_afb, m_we, m_ack, m_ovf;
  int m_count, m_waddr, m_wdata;

  function automatic logic [AW:0] gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    wr_total  = 0;
    rd_total  = 0;
    rd_s1     = 0;
    rd_s2     = 0;
    busy_left = RST_BUSY_CYC;
    m_run     = 0;
    m_full    = 1;
    m_af      = 1;
    m_afb     = 1;
    m_count   = 0;
    m_we      = 0;
    m_ack     = 0;
    m_ovf     = 0;
    m_waddr   = 0;
    m_wdata   = 0;
  endtask

  task automatic model_flags(input int rd_seen);
    m_count = wr_total - rd_seen;
    m_full  = (m_count == DEPTH);
    m_af    = (m_count >= DEPTH - AF_GAP);
    m_afb   = (m_count >= DEPTH - AF_GAP_B);
  endtask

  task automatic model_edge();
    int  rd_seen;
    bit  acc;
    if (rst) begin
      rd_seen = rd_s2;
      rd_s2   = rd_s1;
      rd_s1   = rd_total;
      if (!m_run) begin
        m_we  = 0;
        m_ack = 0;
        m_ovf = 0;
        busy_left--;
        if (busy_left == 0) begin
          m_run = 1;
          model_flags(rd_seen);
        end
      end else begin
        acc   = wr_en && !m_full;
        m_we  = acc;
        m_ack = acc;
        m_ovf = wr_en && m_full;
        if (acc) begin
          m_waddr = wr_total % DEPTH;
          m_wdata = int'(wr_data);
          wr_total++;
        end
        model_flags(rd_seen);
      end
    end
  endtask

  task automatic check_all();
    bit exp_ack, exp_ovf;
`ifdef ASYNC_FIFO_WR_STATUS_EN
    exp_ack = m_ack;
    exp_ovf = m_ovf;
`else
    exp_ack = 0;
    exp_ovf = 0;
`endif
    check("wr_rst_busy", 64'(wr_rst_busy), 64'(!m_run));
    check("full", 64'(full), 64'(m_full));
    check("almost_full", 64'(almost_full), 64'(m_af));
    check("wr_data_count", 64'(wr_data_count), 64'(m_count));
    check("mem_we", 64'(mem_we), 64'(m_we));
    check("mem_waddr", 64'(mem_waddr), 64'(m_waddr));
    check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    check("wr_ptr_gray", 64'(wr_ptr_gray), 64'(gray(wr_total)));
    check("wr_ack", 64'(wr_ack), 64'(exp_ack));
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("af16_almost_full", 64'(b_almost_full), 64'(m_afb));
    check("af16_full", 64'(b_full), 64'(m_full));
    check("af16_count", 64'(b_wr_data_count), 64'(m_count));
  endtask

  // Called positioned at a negedge; drives inputs, advances one edge,
  // checks #1 after it, and returns at the next negedge.
  task automatic do_cycle(input bit we, input bit rd_step);
    if (rd_step && rd_total < wr_total) rd_total++;
    wr_en       = we;
    wr_data     = DW'($urandom_range(0, 255));
    rd_ptr_gray = gray(rd_total);
    @(posedge wr_clk);
    model_edge();
    #1;
    check_all();
    @(negedge wr_clk);
  endtask

  initial begin
    int guard;
    model_reset();
    rst   = 1'b0;
    wr_en = 1'b1;
    @(negedge wr_clk);
    check_all();

    // Reset held three cycles with wr_en high, then release and stream
    // until full and beyond to provoke overflow.
    repeat (3) do_cycle(1'b1, 1'b0);
    rst = 1'b1;
    repeat (RST_BUSY_CYC + DEPTH + 4) do_cycle(1'b1, 1'b0);

    // One pop releases full a few cycles later; the next write lands at 0.
    do_cycle(1'b0, 1'b1);
    repeat (4) do_cycle(1'b0, 1'b0);
    repeat (4) do_cycle(1'b1, 1'b0);

    // Read side tracking random writes: pointer and address wrap repeatedly.
    repeat (1500) do_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 80);

    // Drain, then refill to 100 and hit reset in the middle of the cycle.
    guard = 0;
    while ((m_count != 0 || rd_total != wr_total) && guard < 600) begin
      do_cycle(1'b0, 1'b1);
      guard++;
    end
    check("drain_bound", 64'(m_count), 64'd0);
    guard = 0;
    while (m_count < 100 && guard < 400) begin
      do_cycle(1'b1, 1'b0);
      guard++;
    end
    check("fill_to_100", 64'(wr_data_count), 64'd100);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge wr_clk);
    rd_ptr_gray = '0;
    repeat (2) do_cycle(1'b1, 1'b0);
    rst = 1'b1;
    repeat (40) do_cycle($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_port.md
Name: async_fifo_wr_port

Overview:
Write-side responder of the team's dual-clock FIFO: accepts wr_en/wr_data from the FIFO write driver in the wr_clk domain. Owns the write pointer, the dual-port RAM write port, full/almost_full generation and the post-reset busy window. It exports the Gray write pointer to the read-domain half and takes back the read pointer through a 2-FF synchronizer.

Parameters:
DW, 8, data width
AW, 8, RAM address width; DEPTH = 2**AW (≥4, so AW≥2)
AF_GAP, 1, almost_full asserts when occupancy ≥ DEPTH-AF_GAP (1..DEPTH-1)
RST_BUSY_CYC, 4, wr_clk cycles wr_rst_busy stays high after rst release (≥1)

Ports:
wr_clk  in  1  write clock
rst  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wr_data  in  DW  write data
rd_ptr_gray  in  AW+1  read pointer, Gray, read clock domain
wr_ptr_gray  out  AW+1  registered write pointer, Gray, to read domain
mem_we  out  1  RAM write enable
mem_waddr  out  AW  RAM write address
mem_wdata  out  DW  RAM write data
full  out  1  FIFO full / write not possible
almost_full  out  1  occupancy ≥ DEPTH-AF_GAP
wr_rst_busy  out  1  block in post-reset busy window
wr_data_count  out  AW+1  occupancy seen from write side, 0..DEPTH
wr_ack  out  1  previous-cycle write accepted
overflow  out  1  previous-cycle write rejected because full

Behaviour:
- Reset (rst low, async): state BUSY; wr_rst_busy=1, full=1, almost_full=1; wr_ptr bin/Gray=0, sync regs=0, mem_we=0, mem_waddr=0, mem_wdata=0, wr_data_count=0, wr_ack=0, overflow=0.
- FSM: BUSY -> RUN once busy counter reaches RST_BUSY_CYC after rst release; RUN only exits via rst. Leaving BUSY: wr_rst_busy=0, full/almost_full/count take computed values the same edge.
- In BUSY, wr_en ignored: no RAM write, no ack, no overflow.
- Accept = RUN && wr_en && !full (registered full). Accepted write: next edge mem_we=1, mem_waddr=wr_ptr_bin[AW-1:0], mem_wdata=wr_data, wr_ack=1, wr_ptr_bin+1 (mod 2**(AW+1)), wr_ptr_gray = next_bin ^ (next_bin>>1) on same edge. Latency 1 cycle; back-to-back writes every cycle allowed.
- Rejected (RUN && wr_en && full): overflow=1 for one cycle, pointer/RAM unchanged. mem_we/wr_ack/overflow are single-cycle, otherwise 0.
- rd_ptr_gray through 2-FF sync (rd_sync); rd_bin = Gray-to-binary(rd_sync).
- full (registered) = next_wr_gray == {~rd_sync[AW:AW-1], rd_sync[AW-2:0]}.
- wr_data_count (registered) = next_wr_bin - rd_bin, mod 2**(AW+1); almost_full = count ≥ DEPTH-AF_GAP.
- Flags pessimistic: read-side pop releases full ≤3 wr_clk later (2 sync + 1 register); full never deasserts early.
- Wrap: pointer MSB toggles each DEPTH writes; mem_waddr wraps DEPTH-1 -> 0 seamlessly.
- Write on edge where full asserts: accepted (full evaluated on prior value, includes this write), next wr_en rejected.
- rst mid-stream: all above reset immediately; in-flight mem_we dropped; read-domain half is reset by the same system reset.

Optional Feature:
ASYNC_FIFO_WR_STATUS_EN: defined -> wr_ack and overflow generated as above. Undefined -> both driven constant 0, their registers removed; all other behaviour identical.

Decomposition:
- Package fifo_pkg: bin2gray/gray2bin functions, FSM state encodings (ST_BUSY, ST_RUN), DEPTH derivation from AW.
- One sub-module: cdc_sync_2ff (parameter W), used for rd_ptr_gray; reused by the read-side half.

Test Plan:
- rst low 3 cycles, release, wr_en=1 held -> wr_rst_busy=1 exactly 4 cycles, no mem_we; first mem_we cycle 6 with waddr=0, wr_ack=1.
- rd_ptr_gray=0, 256 consecutive writes -> almost_full after 255th accept, full after 256th, count=256; 257th wr_en -> overflow=1, waddr stays 255.
- Full, then rd_ptr_gray steps to gray(1)=1 -> full=0 within 3 cycles, count=255, next write to waddr 0, wr_ptr_gray=gray(257).
- Read side tracks writes; 600 writes -> mem_waddr wraps 255->0 twice, wr_ptr bin wraps 511->0, never full/overflow.
- AF_GAP=16, rd static 0 -> almost_full rises once count=240, full at 256.
- rst asserted mid-burst at count 100 -> same-cycle async clear: count=0, full=1, mem_we=0, busy window restarts.
